// File: rtl/priority_write_arbiter.sv
// Round-robin write arbiter owning a shared 8-bit register: one registered commit per grant,
// then a HOLD window of HOLD_CYCLES cycles during which requests are ignored.
module priority_write_arbiter #(
    parameter int          INPUT_COUNT = 4,
    parameter int          HOLD_CYCLES = 2,
    parameter logic [7:0]  RESET_VALUE = 8'h00,
    localparam int         IDX_W       = $clog2(INPUT_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic [INPUT_COUNT-1:0]     req_i,
    input  logic [INPUT_COUNT*8-1:0]   req_data_i,
    output logic [7:0]                 data_out_o,
    output logic [INPUT_COUNT-1:0]     ack_o,
    output logic                       write_strobe_o,
    output logic [IDX_W-1:0]           grant_idx_o,
    output logic                       busy_o
);

    localparam int               PTR_W   = IDX_W + 1;
    localparam int               CNT_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [7:0]               data_q, data_d;
    logic [INPUT_COUNT-1:0]   ack_q, ack_d;
    logic                     strobe_q, strobe_d;
    logic [IDX_W-1:0]         gidx_q, gidx_d;

    logic [7:0]               slot [INPUT_COUNT];
    logic                     win_vld;
    logic [IDX_W-1:0]         win_idx;
    logic [IDX_W-1:0]         win_nxt;
    logic [PTR_W-1:0]         cand;

    for (genvar g = 0; g < INPUT_COUNT; g++) begin : g_slot
        assign slot[g] = req_data_i[g*8 +: 8];
    end

    // Search starts at rr_ptr; the extra pointer bit keeps the modulo wrap correct
    // when INPUT_COUNT is not a power of two.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < INPUT_COUNT; k++) begin
            cand = {1'b0, rr_ptr_q} + PTR_W'(k);
            if (cand >= PTR_W'(INPUT_COUNT)) begin
                cand = cand - PTR_W'(INPUT_COUNT);
            end
            if (!win_vld && req_i[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign win_nxt = (win_idx == IDX_W'(INPUT_COUNT - 1)) ? '0 : win_idx + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        ack_d    = '0;
        strobe_d = 1'b0;
        gidx_d   = gidx_q;
        if (clr_i) begin
            // grant_idx intentionally survives a soft clear
            state_d  = ST_IDLE;
            cnt_d    = '0;
            rr_ptr_d = '0;
            data_d   = RESET_VALUE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        data_d   = slot[win_idx];
                        ack_d    = INPUT_COUNT'(1) << win_idx;
                        strobe_d = 1'b1;
                        gidx_d   = win_idx;
                        rr_ptr_d = win_nxt;
                        cnt_d    = HOLD_LD;
                        state_d  = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            data_q   <= RESET_VALUE;
            ack_q    <= '0;
            strobe_q <= 1'b0;
            gidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            strobe_q <= strobe_d;
            gidx_q   <= gidx_d;
        end
    end

    assign data_out_o     = data_q;
    assign ack_o          = ack_q;
    assign write_strobe_o = strobe_q;
    assign grant_idx_o    = gidx_q;
    assign busy_o         = (state_q == ST_HOLD);

endmodule

// File: tb/tb_priority_write_arbiter.sv
// Bench for priority_write_arbiter: per-cycle vector table plus a grant-order scoreboard.
module tb_priority_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  data_out;
    logic [3:0]  ack;
    logic        write_strobe;
    logic [1:0]  grant_idx;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] dat;
        logic        clr;
        logic [7:0]  e_dat;
        logic [3:0]  e_ack;
        logic        e_stb;
        logic [1:0]  e_gidx;
        logic        e_busy;
    } vec_t;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] dat;
    } sb_t;

    vec_t tbl [20];
    sb_t  sb_q [$];

    priority_write_arbiter #(
        .INPUT_COUNT(4),
        .HOLD_CYCLES(2),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr_i          (clr),
        .req_i          (req),
        .req_data_i     (req_data),
        .data_out_o     (data_out),
        .ack_o          (ack),
        .write_strobe_o (write_strobe),
        .grant_idx_o    (grant_idx),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic run_sb(input bit drop_on_ack, input int budget, input string tag);
        int         last;
        sb_t        e;
        logic [3:0] onehot;
        last = -1;
        for (int c = 0; c < budget && sb_q.size() > 0; c++) begin
            tick();
            if (write_strobe) begin
                e      = sb_q.pop_front();
                onehot = 4'b0001 << e.idx;
                chk({tag, "_gidx"}, grant_idx, e.idx);
                chk({tag, "_data"}, data_out, e.dat);
                chk({tag, "_ack"}, ack, onehot);
                if (last >= 0) chk({tag, "_gap"}, cyc - last, 3);
                last = cyc;
                if (drop_on_ack) req = req & ~ack;
            end
        end
        if (sb_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout actual=%0d_pending expected=0_pending", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        //            req      dat          clr   data   ack      stb   gidx  busy
        tbl[0]  = '{4'b0100, 32'h00A50000, 1'b0, 8'hA5, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[1]  = '{4'b0000, 32'h00A50000, 1'b0, 8'hA5, 4'b0000, 1'b0, 2'd2, 1'b1};
        tbl[2]  = '{4'b0000, 32'h00A50000, 1'b0, 8'hA5, 4'b0000, 1'b0, 2'd2, 1'b0};
        tbl[3]  = '{4'b0000, 32'h00A50000, 1'b0, 8'hA5, 4'b0000, 1'b0, 2'd2, 1'b0};
        tbl[4]  = '{4'b0000, 32'h00A50000, 1'b0, 8'hA5, 4'b0000, 1'b0, 2'd2, 1'b0};
        tbl[5]  = '{4'b0001, 32'h0000C35A, 1'b0, 8'h5A, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[6]  = '{4'b0010, 32'h0000C35A, 1'b0, 8'h5A, 4'b0000, 1'b0, 2'd0, 1'b1};
        tbl[7]  = '{4'b0010, 32'h0000C35A, 1'b0, 8'h5A, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[8]  = '{4'b0010, 32'h0000C35A, 1'b0, 8'hC3, 4'b0010, 1'b1, 2'd1, 1'b1};
        tbl[9]  = '{4'b0000, 32'h0000C35A, 1'b0, 8'hC3, 4'b0000, 1'b0, 2'd1, 1'b1};
        tbl[10] = '{4'b0000, 32'h0000C35A, 1'b0, 8'hC3, 4'b0000, 1'b0, 2'd1, 1'b0};
        tbl[11] = '{4'b0010, 32'hEE997755, 1'b0, 8'h77, 4'b0010, 1'b1, 2'd1, 1'b1};
        tbl[12] = '{4'b0100, 32'hEE997755, 1'b1, 8'h00, 4'b0000, 1'b0, 2'd1, 1'b0};
        tbl[13] = '{4'b0100, 32'hEE997755, 1'b0, 8'h99, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[14] = '{4'b0000, 32'hEE997755, 1'b0, 8'h99, 4'b0000, 1'b0, 2'd2, 1'b1};
        tbl[15] = '{4'b0000, 32'hEE997755, 1'b0, 8'h99, 4'b0000, 1'b0, 2'd2, 1'b0};
        tbl[16] = '{4'b1001, 32'hEE997755, 1'b1, 8'h00, 4'b0000, 1'b0, 2'd2, 1'b0};
        tbl[17] = '{4'b1001, 32'hEE997755, 1'b0, 8'h55, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[18] = '{4'b0000, 32'hEE997755, 1'b0, 8'h55, 4'b0000, 1'b0, 2'd0, 1'b1};
        tbl[19] = '{4'b0000, 32'hEE997755, 1'b0, 8'h55, 4'b0000, 1'b0, 2'd0, 1'b0};

        rst_n    = 1'b1;
        clr      = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0;

        // Reset asserted between clock edges must take effect without a clock.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_data", data_out, 8'h00);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_stb", write_strobe, 1'b0);
        chk("rst_gidx", grant_idx, 2'd0);
        chk("rst_busy", busy, 1'b0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle%0d_data", i), data_out, 8'h00);
            chk($sformatf("idle%0d_stb", i), write_strobe, 1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            req      = tbl[i].req;
            req_data = tbl[i].dat;
            clr      = tbl[i].clr;
            tick();
            chk($sformatf("row%0d_data", i), data_out, tbl[i].e_dat);
            chk($sformatf("row%0d_ack", i), ack, tbl[i].e_ack);
            chk($sformatf("row%0d_stb", i), write_strobe, tbl[i].e_stb);
            chk($sformatf("row%0d_gidx", i), grant_idx, tbl[i].e_gidx);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
        end
        clr = 1'b0;
        req = 4'b0000;

        // All four requesters, each dropping its request on ack.
        clr = 1'b1;
        tick();
        clr      = 1'b0;
        req_data = 32'h44332211;
        req      = 4'b1111;
        for (int i = 0; i < 4; i++) sb_q.push_back('{idx: 2'(i), dat: 8'(8'h11 * (i + 1))});
        run_sb(1'b1, 20, "all");
        repeat (5) tick();
        chk("all_hold_data", data_out, 8'h44);
        chk("all_hold_busy", busy, 1'b0);
        chk("all_hold_req", req, 4'b0000);

        // Two requesters held continuously must alternate.
        req_data = 32'hF000000F;
        req      = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{idx: 2'd0, dat: 8'h0F});
            sb_q.push_back('{idx: 2'd3, dat: 8'hF0});
        end
        run_sb(1'b0, 30, "fair");
        req = 4'b0000;
        repeat (3) tick();

        // Async reset while ack is high, then rr pointer restarts at 0.
        req      = 4'b0100;
        req_data = 32'h00BB0000;
        tick();
        chk("prerst_ack", ack, 4'b0100);
        chk("prerst_data", data_out, 8'hBB);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ack", ack, 4'b0000);
        chk("midrst_stb", write_strobe, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_data", data_out, 8'h00);
        chk("midrst_gidx", grant_idx, 2'd0);
        #1;
        req      = 4'b1001;
        req_data = 32'h66000055;
        rst_n    = 1'b1;
        tick();
        chk("postrst_ack", ack, 4'b0001);
        chk("postrst_data", data_out, 8'h55);
        chk("postrst_gidx", grant_idx, 2'd0);
        req = 4'b0000;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/priority_write_arbiter.md
Name: priority_write_arbiter

Overview:
- Round-robin write arbiter that owns the shared 8-bit data register.
- Up to INPUT_COUNT requesters compete to write the register. One winner commits per grant, then a hold window blocks further writes.
- Returns a one-cycle ack to the winner and holds the last committed value when nobody requests.
- Replaces the fixed-priority combinational select with a fair, registered, rate-limited scheduler.

Parameters:
- INPUT_COUNT, 4, number of requesters (>=2).
- HOLD_CYCLES, 2, cycles after a commit during which no new grant is issued (>=1).
- RESET_VALUE, 8'h00, value of data_out after reset or clr.
- IDX_W, $clog2(INPUT_COUNT), derived width of grant_idx; not overridden.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clr, input, 1, synchronous soft clear.
- req, input, INPUT_COUNT, request flags; req[i] owns data slot i.
- req_data, input, INPUT_COUNT*8, concatenated write data; slot i = req_data[i*8 +: 8].
- data_out, output, 8, registered shared data register.
- ack, output, INPUT_COUNT, one-hot one-cycle pulse to the committed requester.
- write_strobe, output, 1, one-cycle pulse coincident with ack.
- grant_idx, output, IDX_W, index of the last committed requester (held).
- busy, output, 1, high while in HOLD.

Behaviour:
- Reset (rst_n=0, async): data_out=RESET_VALUE, ack=0, write_strobe=0, grant_idx=0, busy=0, rr_ptr=0, hold counter=0, state=IDLE. Release is synchronous to clk.
- State IDLE, busy=0:
  - On each rising edge with any req bit high, search req starting at rr_ptr in ascending order, wrapping modulo INPUT_COUNT. The first set bit is winner w.
  - On that same edge: data_out<=req_data slot w; ack<=one-hot(w); write_strobe<=1; grant_idx<=w; rr_ptr<=(w+1) mod INPUT_COUNT; counter<=HOLD_CYCLES; state<=HOLD.
  - With no req bit high: all registers hold; ack and write_strobe are 0.
- State HOLD, busy=1:
  - req is ignored. Counter decrements each edge; at 1 -> state<=IDLE.
  - The state occupies exactly HOLD_CYCLES cycles.
  - ack and write_strobe are high only in the first HOLD cycle.
- Latency and throughput:
  - ack and data_out update are visible the cycle after the sampling edge.
  - Successive grant edges are at least HOLD_CYCLES+1 cycles apart.
- Requester contract:
  - Keep req[i] and slot i stable until ack[i] is seen, then drop req[i] within HOLD_CYCLES cycles.
  - A req dropped before ack is a withdrawal; no error is flagged.
  - Data is sampled only on the grant edge.
- Fairness:
  - A continuously requesting requester waits at most INPUT_COUNT-1 other grants.
  - rr_ptr advances only on a commit.
- clr, synchronous:
  - Has priority over any grant on the same edge.
  - Effect: data_out<=RESET_VALUE, rr_ptr<=0, state<=IDLE, counter<=0, ack<=0, write_strobe<=0.
  - grant_idx holds.
  - clr during HOLD aborts the window; a grant is possible on the next edge.
- Async reset mid-HOLD: all state returns to reset values immediately, including an ack that is currently high.
- Out-of-range rr_ptr is unreachable; the wrap logic must handle non-power-of-2 INPUT_COUNT (e.g. 3, 5).
- No combinational path from req or req_data to any output.

Test Plan:
Configuration for all cases: INPUT_COUNT=4, HOLD_CYCLES=2, RESET_VALUE=8'h00.
1. Reset and idle: assert rst_n=0 mid-cycle -> outputs reset immediately (data_out=8'h00, ack=4'b0000, busy=0). Release with req=0 for 10 cycles -> data_out stays 8'h00, no strobe.
2. Single write: req=4'b0100, slot2=8'hA5 at edge E -> after E, data_out=8'hA5, ack=4'b0100 and write_strobe for 1 cycle, grant_idx=2. busy high for 2 cycles, low after edge E+2. Req dropped -> data_out holds 8'hA5 indefinitely.
3. All requesters: slots=8'h11/22/33/44, each req held until its ack -> commits in order 0,1,2,3 at edges E, E+3, E+6, E+9. data_out follows 11,22,33,44 and finally holds 8'h44.
4. Fairness wrap: req0 and req3 held high continuously, slot0=8'h0F, slot3=8'hF0 -> grants alternate 0,3,0,3 every 3 cycles. Neither requester waits more than 1 other grant.
5. Hold masking: req1 rises during the HOLD cycle right after a grant to requester 0 -> no ack until the first IDLE edge. Then ack=4'b0010 with data_out=slot1.
6. clr and reset mid-operation:
   - clr=1 on the first HOLD cycle -> next cycle data_out=8'h00, busy=0, ack=0; a pending req2 is granted on the following edge.
   - Separately, rst_n=0 while ack is high -> ack drops immediately.
   - After release, rr_ptr=0: req=4'b1001 grants requester 0 first.
